// File: rtl/axilite_regfile.sv
// AXI4-Lite slave with 16 x 32-bit registers: reg 0 is a constant ID, regs 1..14 are R/W and
// reg 15 reflects status_in. AW, W and AR are each captured in a one-entry holder.
module axilite_regfile #(
    parameter int unsigned ADDR_W   = 17,
    parameter logic [31:0] ID_VALUE = 32'h0D4A0001
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    input  logic [31:0]       status_in,
    output logic [511:0]      regs_out,
    output logic [15:0]       wr_pulse
);

    logic              rdy_en_q;
    logic              aw_full_q, w_full_q, ar_full_q;
    logic [ADDR_W-1:2] aw_addr_q, ar_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              bvalid_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;
    logic [15:0]       wr_pulse_q;
    logic [31:0]       regs_q [1:14];

    logic [31:0]       reg_view [16];
    logic              aw_oor, ar_oor, commit, wr_en;
    logic [3:0]        aw_idx, ar_idx;
    logic [31:0]       wr_data_d, rdata_d;
    logic [1:0]        rresp_d;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        reg_view[0] = ID_VALUE;
        for (int i = 1; i < 15; i++) begin
            reg_view[i] = regs_q[i];
        end
        reg_view[15] = status_in;
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < 16; i++) begin
            regs_out[32*i +: 32] = reg_view[i];
        end
    end

    assign aw_oor = |aw_addr_q[ADDR_W-1:6];
    assign aw_idx = aw_addr_q[5:2];
    assign ar_oor = |ar_addr_q[ADDR_W-1:6];
    assign ar_idx = ar_addr_q[5:2];
    assign commit = aw_full_q & w_full_q;
    assign wr_en  = commit & ~aw_oor & (aw_idx != 4'd0) & (aw_idx != 4'd15);

    always_comb begin
        wr_data_d = reg_view[aw_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) wr_data_d[8*b +: 8] = w_data_q[8*b +: 8];
        end
        rdata_d = ar_oor ? 32'h0 : reg_view[ar_idx];
        rresp_d = ar_oor ? 2'b10 : 2'b00;
    end

    // Readies stay low for the first cycle after reset release via rdy_en_q.
    assign s_axi_awready = rdy_en_q & ~aw_full_q & ~bvalid_q;
    assign s_axi_wready  = rdy_en_q & ~w_full_q & ~bvalid_q;
    assign s_axi_arready = rdy_en_q & ~rvalid_q & ~ar_full_q;

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign wr_pulse     = wr_pulse_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_en_q   <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (commit) begin
                aw_full_q  <= 1'b0;
                w_full_q   <= 1'b0;
                bvalid_q   <= 1'b1;
                bresp_q    <= aw_oor ? 2'b10 : 2'b00;
                wr_pulse_q <= wr_en ? (16'h1 << aw_idx) : 16'h0;
            end else begin
                wr_pulse_q <= '0;
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_full_q <= 1'b1;
                    aw_addr_q <= s_axi_awaddr[ADDR_W-1:2];
                end
                if (s_axi_wvalid && s_axi_wready) begin
                    w_full_q <= 1'b1;
                    w_data_q <= s_axi_wdata;
                    w_strb_q <= s_axi_wstrb;
                end
                if (bvalid_q && s_axi_bready) bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < 15; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < 15; i++) begin
                if (wr_en && aw_idx == 4'(i)) regs_q[i] <= wr_data_d;
            end
        end
    end

    // Read data is taken from the current register values, so a same-edge commit is not seen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_full_q <= 1'b0;
            ar_addr_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= s_axi_araddr[ADDR_W-1:2];
            end
            if (ar_full_q) begin
                ar_full_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= rdata_d;
                rresp_q   <= rresp_d;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axilite_regfile.sv
// Directed self-checking bench for axilite_regfile.
module tb_axilite_regfile;

    localparam logic [31:0] IdValue = 32'h0D4A0001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [16:0] awaddr, araddr;
    logic [31:0] wdata, rdata, status_in;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [511:0] regs_out;
    logic [15:0] wr_pulse;

    int total = 0;
    int bad = 0;

    axilite_regfile #(.ADDR_W(17), .ID_VALUE(IdValue)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_bresp(bresp), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_araddr(araddr), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .status_in(status_in),
        .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [15:0] pulse, output bit to);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0; to = 0; resp = 2'bxx; pulse = 16'hxxxx;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step(); n++;
            if (aw_hs) begin awvalid = 0; aw_done = 1; end
            if (w_hs) begin wvalid = 0; w_done = 1; end
        end
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        if (!bvalid) to = 1;
        else begin resp = bresp; pulse = wr_pulse; step(); end
        bready = 0;
    endtask

    task automatic do_read(input logic [16:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit to);
        bit hs;
        int n;
        n = 0; to = 0; hs = 0; d = 'x; resp = 2'bxx;
        araddr = a; arvalid = 1;
        while (!hs && n < 20) begin
            hs = arvalid && arready;
            step(); n++;
        end
        arvalid = 0; rready = 1;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        if (!rvalid || !hs) to = 1;
        else begin d = rdata; resp = rresp; step(); end
        rready = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        #2;
        total++; if ({awready, wready, arready} !== 3'b000) begin bad++;
            $display("FAIL reset_readies got=%b want=000", {awready, wready, arready}); end
        total++; if ({bvalid, rvalid, bresp, rresp, rdata, wr_pulse} !== '0) begin bad++;
            $display("FAIL reset_outputs got bv=%b rv=%b rdata=%h pulse=%h want zero",
                     bvalid, rvalid, rdata, wr_pulse); end
        total++; if (regs_out[31:0] !== IdValue || regs_out[479:32] !== '0) begin bad++;
            $display("FAIL reset_regs got reg0=%h reg1=%h want %h/0", regs_out[31:0],
                     regs_out[63:32], IdValue); end
        step();
        resetn = 1;
        #1;
        total++; if ({awready, wready, arready} !== 3'b000) begin bad++;
            $display("FAIL first_cycle_readies got=%b want=000", {awready, wready, arready}); end
        step();
        total++; if ({awready, wready, arready} !== 3'b111) begin bad++;
            $display("FAIL second_cycle_readies got=%b want=111", {awready, wready, arready}); end
    endtask

    task automatic test_write_basic();
        awaddr = 17'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        #1;
        total++; if ({awready, wready} !== 2'b11) begin bad++;
            $display("FAIL wr_basic_ready got=%b want=11", {awready, wready}); end
        step();
        awvalid = 0; wvalid = 0;
        total++; if (bvalid !== 1'b0 || regs_out[63:32] !== 32'h0) begin bad++;
            $display("FAIL wr_basic_e0 got bv=%b reg1=%h want 0/0", bvalid, regs_out[63:32]); end
        step();
        total++; if (regs_out[63:32] !== 32'hDEADBEEF || wr_pulse !== 16'h0002 ||
                     bvalid !== 1'b1 || bresp !== 2'b00) begin bad++;
            $display("FAIL wr_basic_e1 got reg1=%h pulse=%h bv=%b bresp=%b want DEADBEEF/0002/1/00",
                     regs_out[63:32], wr_pulse, bvalid, bresp); end
        bready = 1;
        step();
        bready = 0;
        total++; if (bvalid !== 1'b0 || wr_pulse !== 16'h0 || {awready, wready} !== 2'b11) begin
            bad++;
            $display("FAIL wr_basic_after_b got bv=%b pulse=%h rdy=%b want 0/0000/11",
                     bvalid, wr_pulse, {awready, wready}); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [15:0] pulse; bit to;
        do_write(17'h8, 32'hFFFFFFFF, 4'hF, resp, pulse, to);
        total++; if (to || regs_out[95:64] !== 32'hFFFFFFFF) begin bad++;
            $display("FAIL preset_reg2 got=%h to=%0d want FFFFFFFF", regs_out[95:64], to); end
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1;
        step();
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            total++; if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin bad++;
                $display("FAIL w_held_%0d got awr=%b wr=%b bv=%b want 1/0/0", i, awready, wready,
                         bvalid); end
            if (i < 2) step();
        end
        awaddr = 17'h8; awvalid = 1;
        step();
        awvalid = 0;
        step();
        total++; if (regs_out[95:64] !== 32'hFF22FF44 || wr_pulse !== 16'h0004 || bvalid !== 1)
        begin bad++;
            $display("FAIL wstrb_merge got reg2=%h pulse=%h bv=%b want FF22FF44/0004/1",
                     regs_out[95:64], wr_pulse, bvalid); end
        bready = 1;
        step();
        bready = 0;
    endtask

    task automatic test_reads();
        logic [31:0] d; logic [1:0] resp; bit to;
        do_read(17'h0, d, resp, to);
        total++; if (to || d !== IdValue || resp !== 2'b00) begin bad++;
            $display("FAIL read_id got=%h resp=%b want %h/00", d, resp, IdValue); end
        status_in = 32'hA5A5A5A5;
        do_read(17'h3C, d, resp, to);
        total++; if (to || d !== 32'hA5A5A5A5 || resp !== 2'b00) begin bad++;
            $display("FAIL read_status got=%h resp=%b want A5A5A5A5/00", d, resp); end
        do_read(17'h40, d, resp, to);
        total++; if (to || d !== 32'h0 || resp !== 2'b10) begin bad++;
            $display("FAIL read_oor got=%h resp=%b want 0/10", d, resp); end
        do_read(17'h8, d, resp, to);
        total++; if (to || d !== 32'hFF22FF44 || resp !== 2'b00) begin bad++;
            $display("FAIL read_reg2 got=%h resp=%b want FF22FF44/00", d, resp); end
    endtask

    task automatic test_write_oor_ro();
        logic [1:0] resp; logic [15:0] pulse; bit to;
        do_write(17'h10000, 32'h12345678, 4'hF, resp, pulse, to);
        total++; if (to || resp !== 2'b10 || pulse !== 16'h0) begin bad++;
            $display("FAIL write_oor got resp=%b pulse=%h want 10/0000", resp, pulse); end
        do_write(17'h10004, 32'h0, 4'hF, resp, pulse, to);
        total++; if (to || resp !== 2'b10 || pulse !== 16'h0 || regs_out[63:32] !== 32'hDEADBEEF)
        begin bad++;
            $display("FAIL write_oor_alias got resp=%b pulse=%h reg1=%h want 10/0000/DEADBEEF",
                     resp, pulse, regs_out[63:32]); end
        do_write(17'h0, 32'h0, 4'hF, resp, pulse, to);
        total++; if (to || resp !== 2'b00 || pulse !== 16'h0 || regs_out[31:0] !== IdValue) begin
            bad++;
            $display("FAIL write_reg0 got resp=%b pulse=%h reg0=%h want 00/0000/%h", resp, pulse,
                     regs_out[31:0], IdValue); end
        do_write(17'h3C, 32'h0, 4'hF, resp, pulse, to);
        total++; if (to || resp !== 2'b00 || pulse !== 16'h0) begin bad++;
            $display("FAIL write_reg15 got resp=%b pulse=%h want 00/0000", resp, pulse); end
        total++; if (regs_out[95:64] !== 32'hFF22FF44 || regs_out[479:96] !== '0) begin bad++;
            $display("FAIL regs_unchanged got reg2=%h want FF22FF44, regs 3..14 zero",
                     regs_out[95:64]); end
    endtask

    task automatic test_b_stall();
        awaddr = 17'h10008; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        step();
        awvalid = 0; wvalid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            total++; if (bvalid !== 1 || bresp !== 2'b10 || awready !== 0 || wready !== 0) begin
                bad++;
                $display("FAIL b_stall_%0d got bv=%b bresp=%b awr=%b wr=%b want 1/10/0/0", i,
                         bvalid, bresp, awready, wready); end
            step();
        end
        bready = 1;
        step();
        bready = 0;
        total++; if (bvalid !== 0 || {awready, wready} !== 2'b11) begin bad++;
            $display("FAIL b_stall_release got bv=%b rdy=%b want 0/11", bvalid, {awready, wready});
        end
    endtask

    task automatic test_r_stall();
        araddr = 17'h4; arvalid = 1; rready = 0;
        step();
        arvalid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            total++; if (rvalid !== 1 || rdata !== 32'hDEADBEEF || rresp !== 0 || arready !== 0)
            begin bad++;
                $display("FAIL r_stall_%0d got rv=%b rdata=%h arr=%b want 1/DEADBEEF/0", i,
                         rvalid, rdata, arready); end
            step();
        end
        rready = 1;
        step();
        rready = 0;
        total++; if (rvalid !== 0 || arready !== 1) begin bad++;
            $display("FAIL r_stall_release got rv=%b arr=%b want 0/1", rvalid, arready); end
    endtask

    task automatic test_collision();
        logic [1:0] resp; logic [15:0] pulse; logic [31:0] d; bit to;
        do_write(17'hC, 32'h33333333, 4'hF, resp, pulse, to);
        total++; if (to || pulse !== 16'h0008 || regs_out[127:96] !== 32'h33333333) begin bad++;
            $display("FAIL preset_reg3 got reg3=%h pulse=%h want 33333333/0008",
                     regs_out[127:96], pulse); end
        awaddr = 17'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 17'hC;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        step();
        total++; if (rvalid !== 1 || rdata !== 32'h33333333 || bvalid !== 1 ||
                     regs_out[127:96] !== 32'hCAFEF00D) begin bad++;
            $display("FAIL collision got rv=%b rdata=%h bv=%b reg3=%h want 1/33333333/1/CAFEF00D",
                     rvalid, rdata, bvalid, regs_out[127:96]); end
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
        do_read(17'hC, d, resp, to);
        total++; if (to || d !== 32'hCAFEF00D) begin bad++;
            $display("FAIL collision_followup got=%h want CAFEF00D", d); end
    endtask

    task automatic test_reset_mid();
        awaddr = 17'h14; awvalid = 1;
        step();
        awvalid = 0;
        resetn = 0;
        step();
        resetn = 1;
        step();
        total++; if (awready !== 1 || wready !== 1) begin bad++;
            $display("FAIL mid_reset_ready got awr=%b wr=%b want 1/1", awready, wready); end
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
        step();
        wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            total++; if (bvalid !== 0 || wr_pulse !== 16'h0) begin bad++;
                $display("FAIL mid_reset_no_commit_%0d got bv=%b pulse=%h want 0/0000", i, bvalid,
                         wr_pulse); end
            step();
        end
        total++; if (regs_out[479:32] !== '0 || regs_out[31:0] !== IdValue) begin bad++;
            $display("FAIL mid_reset_regs got reg1=%h reg3=%h reg0=%h want 0/0/%h",
                     regs_out[63:32], regs_out[127:96], regs_out[31:0], IdValue); end
    endtask

    initial begin
        resetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; status_in = '0;
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_reads();
        test_write_oor_ro();
        test_b_stall();
        test_r_stall();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axilite_regfile.md
AXILITE_REGFILE -- requirements
Module: axilite_regfile

Interface
REQ-001 The parameter list SHALL be exactly: ADDR_W, 17, AXI-Lite address width.
REQ-002 The parameter list SHALL include: ID_VALUE, 32'h0D4A0001, constant returned by register 0.
REQ-003 The ports SHALL be, in order:
- clk  in  1  single clock.
- resetn  in  1  asynchronous active-low reset.
REQ-004 The ports SHALL continue:
- s_axi_awvalid/awready  in/out  1  write address handshake.
- s_axi_awaddr  in  ADDR_W.
- s_axi_wvalid/wready  in/out  1.
- s_axi_wdata  in  32.
- s_axi_wstrb  in  4.
- s_axi_bvalid/bready  out/in  1.
- s_axi_bresp  out  2.
REQ-005 The ports SHALL continue:
- s_axi_arvalid/arready  in/out  1.
- s_axi_araddr  in  ADDR_W.
- s_axi_rvalid/rready  out/in  1.
- s_axi_rdata  out  32.
- s_axi_rresp  out  2.
REQ-006 The ports SHALL continue:
- status_in  in  32  hardware status, readable at register 15.
- regs_out  out  512  registers 0..15 flattened, register n at bits [32n+31:32n].
- wr_pulse  out  16  one-cycle strobe per register written.

Function
REQ-007 Register map SHALL decode word offset addr[5:2].
- Reg 0: read-only ID_VALUE.
- Regs 1..14: read/write.
- Reg 15: read-only, returns status_in sampled at the read-data edge.
REQ-008 Any address with addr[ADDR_W-1:6] != 0 SHALL be out of range.
- Write is dropped; bresp = 2'b10 (SLVERR).
- Read returns rdata = 0 with rresp = 2'b10.
REQ-009 Writes to regs 0/15 SHALL be ignored with bresp = 2'b00 and no wr_pulse.
REQ-010 The AW and W channels SHALL be accepted independently, each into its own one-entry holding register.
REQ-011 awready SHALL be high iff the AW holder is empty and bvalid = 0.
REQ-012 wready SHALL be high iff the W holder is empty and bvalid = 0.
REQ-013 The edge after both holders are full SHALL commit:
- Apply the byte lanes where wstrb[i] = 1.
- Set bvalid.
- Clear both holders.
- Pulse wr_pulse[n] for exactly one cycle.
REQ-014 Write latency SHALL be: AW+W handshake at edge E0 -> regs_out and bvalid updated at E1.
REQ-015 bvalid and bresp SHALL hold stable until bready; awready and wready SHALL return high the cycle after the B handshake.
REQ-016 AW arriving before W (or W before AW) by any number of cycles SHALL be held; the holder SHALL not accept a second beat.
REQ-017 arready SHALL be high iff rvalid = 0.
REQ-018 Read latency SHALL be: AR handshake at edge E0 -> rdata, rresp and rvalid registered at E1.
REQ-019 rvalid, rdata and rresp SHALL hold stable until rready; a new AR SHALL be acceptable the cycle after the R handshake.
REQ-020 The read and write paths SHALL operate concurrently.
- A read whose data edge coincides with a commit to the same register returns the pre-write value.
REQ-021 bresp/rresp SHALL only be 2'b00 or 2'b10.
REQ-022 wr_pulse SHALL be a registered output with at most one bit high per cycle.

Reset
REQ-023 While resetn = 0, asynchronously:
- All of the following low: awready, wready, arready, bvalid, rvalid, wr_pulse.
- bresp = rresp = 0; rdata = 0.
- Holders empty.
- Regs 1..14 = 0; reg 0 = ID_VALUE.
REQ-024 Reset mid-transaction SHALL discard held AW/W/AR and any pending response.
- No commit occurs after reset release.
REQ-025 The first cycle after reset release SHALL keep all readies low.
- awready, wready and arready go high from the second cycle.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- AW 0x04 and W 0xDEADBEEF with wstrb 0xF in the same cycle -> at E1 regs_out[63:32] = 0xDEADBEEF, wr_pulse = 0x0002, bvalid = 1, bresp = 0.
- W 0x11223344 with wstrb 0x5 to reg 2 (preset 0xFFFFFFFF), W issued 3 cycles before AW -> reg 2 = 0xFF22FF44, awready stays high until AW arrives.
- Read 0x00 -> rdata = ID_VALUE, rresp = 0.
- Read 0x3C with status_in = 0xA5A5A5A5 -> rdata = 0xA5A5A5A5.
- Read 0x40 -> rdata = 0, rresp = 2'b10.
- Write 0x1_0000 -> bresp = 2'b10, no register change, wr_pulse = 0.
- bready held low 5 cycles -> bvalid and bresp stable, awready/wready low throughout.
- rready held low 5 cycles -> rvalid and rdata stable.
- Read reg 3 whose data edge equals the commit of a write to reg 3 -> old value returned; a following read returns the new value.
- resetn pulsed low with AW held but W absent -> after release, a W alone produces no bvalid and reg contents are 0.
